// File: rtl/sc_adder_chain_ctrl.sv
// Sequencing controller for an N-input stochastic adder chain.
// Loads the operand SNGs, streams for L cycles, and keeps the select
// generators running through the chain's N-2 cycle alignment latency.
// It counts 1s on the chain output inside the L-cycle valid window
// and reports the count with a start/busy/done handshake.
module sc_adder_chain_ctrl #(
  parameter int N     = 4,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] stream_len,
  input  logic             sum_in,
  output logic             sng_load,
  output logic             sng_en,
  output logic             sel_en,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] result
);

  // One cycle counter runs across STREAM and DRAIN, so it must hold L+N-3.
  localparam int CNT_W = LEN_W + $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAT = CNT_W'(N - 2);
  localparam bit NO_DRAIN = (N == 2);

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   ones_reg;
  logic [LEN_W-1:0]   result_reg;
  logic [CNT_W-1:0]   cyc_reg;
  logic [CNT_W-1:0]   len_ext;
  logic               stream_last;
  logic               drain_last;
  logic               win_open;
  logic               count_en;
  logic               accept;

  assign len_ext     = CNT_W'(len_q);
  assign stream_last = (cyc_reg + CNT_W'(1)) == len_ext;
  assign drain_last  = (cyc_reg + CNT_W'(1)) == (len_ext + LAT);
  assign accept      = (state_reg == IDLE) && start && !abort;

  // The window opens once the first operand bits have propagated through
  // the chain (N-2 cycles into STREAM); with N==2 there is no latency.
  generate
    if (N == 2) begin : g_no_lat
      assign win_open = 1'b1;
    end else begin : g_lat
      assign win_open = (cyc_reg >= LAT);
    end
  endgenerate

  assign count_en = ((state_reg == STREAM) || (state_reg == DRAIN)) && win_open && sum_in;

  // The result is already valid in the DONE cycle, before it is latched.
  assign result = (state_reg == DONE) ? ones_reg : result_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and Moore outputs; abort wins over every other exit.
  always_comb begin
    state_next = state_reg;
    sng_load   = 1'b0;
    sng_en     = 1'b0;
    sel_en     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !abort) state_next = LOAD;
      end
      LOAD: begin
        sng_load = 1'b1;
        busy     = 1'b1;
        if (abort)             state_next = IDLE;
        else if (len_q == '0)  state_next = DONE;
        else                   state_next = STREAM;
      end
      STREAM: begin
        sng_en = 1'b1;
        sel_en = 1'b1;
        busy   = 1'b1;
        if (abort)            state_next = IDLE;
        else if (stream_last) state_next = NO_DRAIN ? DONE : DRAIN;
      end
      DRAIN: begin
        sel_en = 1'b1;
        busy   = 1'b1;
        if (abort)           state_next = IDLE;
        else if (drain_last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, cycle/ones counters and result latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      cyc_reg    <= '0;
      ones_reg   <= '0;
      result_reg <= '0;
    end else begin
      if (accept) len_q <= stream_len;

      if (state_reg == LOAD) begin
        cyc_reg  <= '0;
        ones_reg <= '0;
      end else begin
        if ((state_reg == STREAM) || (state_reg == DRAIN)) cyc_reg <= cyc_reg + CNT_W'(1);
        if (count_en) ones_reg <= ones_reg + LEN_W'(1);
      end

      if (state_reg == DONE) result_reg <= ones_reg;
    end
  end

endmodule

// File: tb/tb_sc_adder_chain_ctrl.sv
// Bench for sc_adder_chain_ctrl: an N=4 and an N=2 instance share one
// stimulus stream; a cycle-indexed model of the timing rules predicts
// every output each cycle, and literal values pin the key results.
module tb_sc_adder_chain_ctrl;

  localparam int LEN_W = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [LEN_W-1:0] stream_len = '0;
  logic             sum_in = 1'b0;

  logic             sng_load [2];
  logic             sng_en   [2];
  logic             sel_en   [2];
  logic             busy     [2];
  logic             done     [2];
  logic [LEN_W-1:0] result   [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state per instance (0: N=4, 1: N=2).
  int nn       [2] = '{4, 2};
  bit active   [2];
  int t0       [2];
  int lm       [2];
  int ones_m   [2];
  int exp_res  [2];
  int done_k   [2];
  int done_cnt [2];

  always #5 clk = ~clk;

  sc_adder_chain_ctrl #(.N(4), .LEN_W(LEN_W)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .stream_len(stream_len), .sum_in(sum_in),
    .sng_load(sng_load[0]), .sng_en(sng_en[0]), .sel_en(sel_en[0]),
    .busy(busy[0]), .done(done[0]), .result(result[0])
  );

  sc_adder_chain_ctrl #(.N(2), .LEN_W(LEN_W)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .stream_len(stream_len), .sum_in(sum_in),
    .sng_load(sng_load[1]), .sng_en(sng_en[1]), .sel_en(sel_en[1]),
    .busy(busy[1]), .done(done[1]), .result(result[1])
  );

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp_v);
    end
  endtask

  // Model update: accept, count window, DONE/abort/reset per the timing rules.
  always @(posedge clk) begin
    int k;
    int endk;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        active[i]  = 1'b0;
        ones_m[i]  = 0;
        exp_res[i] = 0;
      end else if (active[i]) begin
        k    = cyc - t0[i];
        endk = (lm[i] == 0) ? 2 : lm[i] + nn[i];
        if (lm[i] > 0 && k >= nn[i] && k <= lm[i] + nn[i] - 1 && sum_in) ones_m[i]++;
        if (k == endk) begin
          exp_res[i] = ones_m[i];
          active[i]  = 1'b0;
        end else if (abort) begin
          active[i] = 1'b0;
        end
      end else if (start && !abort) begin
        active[i] = 1'b1;
        t0[i]     = cyc;
        lm[i]     = int'(stream_len);
        ones_m[i] = 0;
      end
    end
    cyc++;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    int k;
    int endk;
    int e_load, e_en, e_sel, e_busy, e_done, e_res;
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        k = 0;
        e_load = 0; e_en = 0; e_sel = 0; e_busy = 0; e_done = 0;
        e_res = exp_res[i];
        if (active[i]) begin
          k      = cyc - t0[i];
          endk   = (lm[i] == 0) ? 2 : lm[i] + nn[i];
          e_load = int'(k == 1);
          e_en   = int'(lm[i] > 0 && k >= 2 && k <= lm[i] + 1);
          e_sel  = int'(lm[i] > 0 && k >= 2 && k <= lm[i] + nn[i] - 1);
          e_busy = int'(k >= 1 && k < endk);
          e_done = int'(k == endk);
          if (k == endk) e_res = ones_m[i];
        end
        chk($sformatf("n%0d_sng_load", nn[i]), int'(sng_load[i]), e_load);
        chk($sformatf("n%0d_sng_en", nn[i]),   int'(sng_en[i]),   e_en);
        chk($sformatf("n%0d_sel_en", nn[i]),   int'(sel_en[i]),   e_sel);
        chk($sformatf("n%0d_busy", nn[i]),     int'(busy[i]),     e_busy);
        chk($sformatf("n%0d_done", nn[i]),     int'(done[i]),     e_done);
        chk($sformatf("n%0d_result", nn[i]),   int'(result[i]),   e_res);
        if (done[i]) begin
          done_k[i] = active[i] ? k : -1;
          done_cnt[i]++;
        end
      end
    end
  end

  // One run: start at relative cycle 0, then drive ncyc more cycles.
  // sum_in is constant 1 unless use_mask, in which case mask[k] gives it.
  task automatic run(input int l, input bit use_mask, input logic [31:0] mask,
                     input int abort_k, input int rst_k, input int start2_k,
                     input int ncyc);
    for (int k = 0; k <= ncyc; k++) begin
      start      = (k == 0) || (k == start2_k);
      stream_len = (k == 0) ? l[LEN_W-1:0] : 10'h155;
      abort      = (k == abort_k);
      rst        = (k == rst_k);
      sum_in     = use_mask ? ((k < 32) ? mask[k] : 1'b0) : 1'b1;
      @(negedge clk);
    end
    start  = 1'b0;
    abort  = 1'b0;
    rst    = 1'b0;
    sum_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int dc0, dc1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_result_n4", int'(result[0]), 0);
    chk("reset_busy_n4", int'(busy[0]), 0);

    // L=8, sum_in constant 1.
    run(8, 1'b0, 32'h0, -1, -1, -1, 14);
    chk("l8_ones_done_k_n4", done_k[0], 12);
    chk("l8_ones_result_n4", int'(result[0]), 8);
    chk("l8_ones_done_k_n2", done_k[1], 10);
    chk("l8_ones_result_n2", int'(result[1]), 8);

    // 1s only on cycles 3 and 12: outside the N=4 window.
    run(8, 1'b1, (32'd1 << 3) | (32'd1 << 12), -1, -1, -1, 14);
    chk("outside_result_n4", int'(result[0]), 0);
    chk("outside_result_n2", int'(result[1]), 1);

    // 1s on cycles 4, 7, 11.
    run(8, 1'b1, (32'd1 << 4) | (32'd1 << 7) | (32'd1 << 11), -1, -1, -1, 14);
    chk("sparse_result_n4", int'(result[0]), 3);
    chk("sparse_result_n2", int'(result[1]), 2);

    // L=5: the N=2 instance has no DRAIN.
    run(5, 1'b0, 32'h0, -1, -1, -1, 10);
    chk("l5_done_k_n2", done_k[1], 7);
    chk("l5_result_n2", int'(result[1]), 5);
    chk("l5_done_k_n4", done_k[0], 9);

    // L=0: straight from LOAD to DONE.
    run(0, 1'b0, 32'h0, -1, -1, -1, 5);
    chk("l0_done_k_n4", done_k[0], 2);
    chk("l0_result_n4", int'(result[0]), 0);

    // Maximum length.
    run(1023, 1'b0, 32'h0, -1, -1, -1, 1030);
    chk("lmax_done_k_n4", done_k[0], 1027);
    chk("lmax_result_n4", int'(result[0]), 1023);
    chk("lmax_result_n2", int'(result[1]), 1023);

    // Abort on cycle 5: no done, result keeps 1023.
    dc0 = done_cnt[0];
    dc1 = done_cnt[1];
    run(8, 1'b0, 32'h0, 5, -1, -1, 14);
    chk("abort_no_done_n4", done_cnt[0], dc0);
    chk("abort_no_done_n2", done_cnt[1], dc1);
    chk("abort_result_n4", int'(result[0]), 1023);

    // Start pulse while busy is ignored.
    dc0 = done_cnt[0];
    run(8, 1'b0, 32'h0, -1, -1, 4, 14);
    chk("busy_start_done_cnt_n4", done_cnt[0], dc0 + 1);
    chk("busy_start_done_k_n4", done_k[0], 12);

    // Start in the N=4 DONE cycle is ignored there (N=2 is idle and takes it).
    dc0 = done_cnt[0];
    run(8, 1'b0, 32'h0, -1, -1, 12, 26);
    chk("done_start_done_cnt_n4", done_cnt[0], dc0 + 1);

    // Abort together with start in IDLE: nothing starts.
    dc0 = done_cnt[0];
    run(8, 1'b0, 32'h0, 0, -1, -1, 5);
    chk("abort_start_done_cnt_n4", done_cnt[0], dc0);

    // Reset on cycle 6 clears everything, including the result.
    dc0 = done_cnt[0];
    run(8, 1'b0, 32'h0, -1, 6, -1, 14);
    chk("rst_result_n4", int'(result[0]), 0);
    chk("rst_result_n2", int'(result[1]), 0);
    chk("rst_no_done_n4", done_cnt[0], dc0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
